// File: rtl/opb_register_simulink2ppc_snap.sv
// OPB slave that snapshots a 32-bit word from user logic and returns it to the PPC.
// Software polls STATUS, reads DATA, and freezes capture or clears flags through CTRL.
module opb_register_simulink2ppc_snap #(
  parameter logic [31:0] C_BASEADDR   = 32'h01080400,
  parameter logic [31:0] C_HIGHADDR   = 32'h010804FF,
  parameter int          C_OPB_AWIDTH = 32,
  parameter int          C_OPB_DWIDTH = 32,
  parameter              C_FAMILY     = "virtex5"
) (
  input  logic                      OPB_Clk,
  input  logic                      OPB_Rst_n,
  input  logic [0:C_OPB_AWIDTH-1]   OPB_ABus,
  input  logic [0:C_OPB_DWIDTH/8-1] OPB_BE,
  input  logic [0:C_OPB_DWIDTH-1]   OPB_DBus,
  input  logic                      OPB_RNW,
  input  logic                      OPB_select,
  input  logic                      OPB_seqAddr,
  output logic [0:C_OPB_DWIDTH-1]   Sl_DBus,
  output logic                      Sl_xferAck,
  output logic                      Sl_errAck,
  output logic                      Sl_retry,
  output logic                      Sl_toutSup,
  input  logic [31:0]               user_data_in,
  input  logic                      user_valid
);

  localparam int unusedFamilyLen = $bits(C_FAMILY);

  typedef enum logic [1:0] {IDLE, ACK, HOLD} state_e;

  state_e      state_q, state_d;
  logic [31:0] dataWord_q, dataWord_d;
  logic        newFlag_q, newFlag_d;
  logic        ovf_q, ovf_d;
  logic [15:0] cnt_q, cnt_d;
  logic        freeze_q, freeze_d;

  logic [31:0] addr;
  logic [31:0] offset;
  logic [31:0] wdata;
  logic [5:0]  wordIdx;
  logic        inWindow;
  logic        ackRead, ackWrite;
  logic        dataRead, ctrlWrite, clr, capture;
  logic [31:0] rdata;
  logic        unusedBits;

  // Bus vectors are MSB-first ([0] is bit 31); plain assignment keeps numeric value.
  assign addr     = OPB_ABus;
  assign wdata    = OPB_DBus;
  assign offset   = addr - C_BASEADDR;
  assign wordIdx  = offset[7:2];
  assign inWindow = (addr >= C_BASEADDR) && (addr <= C_HIGHADDR);

  assign unusedBits = ^{OPB_seqAddr, OPB_BE[1:3], wdata[29:0], offset[31:8], offset[1:0]};

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (OPB_select && inWindow) state_d = ACK;
      ACK:     state_d = HOLD;
      HOLD:    if (!OPB_select) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign ackRead   = (state_q == ACK) && OPB_RNW;
  assign ackWrite  = (state_q == ACK) && !OPB_RNW;
  assign dataRead  = ackRead && (wordIdx == 6'd0);
  assign ctrlWrite = ackWrite && (wordIdx == 6'd2) && OPB_BE[0];
  assign clr       = ctrlWrite && wdata[30];
  assign capture   = user_valid && !freeze_q;

  always_comb begin
    rdata = 32'h0;
    case (wordIdx)
      6'd0:    rdata = dataWord_q;
      6'd1:    rdata = {newFlag_q, ovf_q, 14'h0, cnt_q};
      6'd2:    rdata = {freeze_q, 31'h0};
      default: rdata = 32'h0;
    endcase
  end

  // A read-clear or CLR lands before capture, so a coincident capture re-arms NEW.
  always_comb begin
    dataWord_d = dataWord_q;
    newFlag_d  = newFlag_q;
    ovf_d      = ovf_q;
    cnt_d      = cnt_q;
    freeze_d   = freeze_q;
    if (dataRead) newFlag_d = 1'b0;
    if (clr) begin
      newFlag_d = 1'b0;
      ovf_d     = 1'b0;
      cnt_d     = 16'h0;
    end
    if (ctrlWrite) freeze_d = wdata[31];
    if (capture) begin
      dataWord_d = user_data_in;
      newFlag_d  = 1'b1;
      cnt_d      = cnt_d + 16'h1;
      if (newFlag_q && !clr && !dataRead) ovf_d = 1'b1;
    end
  end

  always_ff @(posedge OPB_Clk) begin
    if (!OPB_Rst_n) begin
      state_q    <= IDLE;
      dataWord_q <= 32'h0;
      newFlag_q  <= 1'b0;
      ovf_q      <= 1'b0;
      cnt_q      <= 16'h0;
      freeze_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      dataWord_q <= dataWord_d;
      newFlag_q  <= newFlag_d;
      ovf_q      <= ovf_d;
      cnt_q      <= cnt_d;
      freeze_q   <= freeze_d;
    end
  end

  assign Sl_xferAck = (state_q == ACK);
  assign Sl_DBus    = ackRead ? rdata : 32'h0;
  assign Sl_errAck  = 1'b0;
  assign Sl_retry   = 1'b0;
  assign Sl_toutSup = 1'b0;

endmodule
